// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard and stall controller for the 5-stage core. It decides, every
// cycle, which pipeline registers freeze and which load a bubble. The decision
// is based on the data-memory handshake, the EX-stage redirect, the
// post-redirect wrong-path flush window, load-use hazards and fetch readiness.
// It also keeps a data-memory wait watchdog and saturating performance
// counters.
//
// Parameters
//   REDIRECT_BUBBLES  ifid_flush cycles per redirect, redirect cycle included (>=1)
//   TIMEOUT           consecutive stall cycles before mem_timeout sets (0 = off)
//   CNT_W             width of the performance counters
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   ifid_rs1/rs2, ifid_uses_rs1/2   ID-stage source registers and their use
//   idex_rd, idex_mem_read          EX-stage destination and load flag
//   ex_redirect                     taken branch/jump resolved in EX
//   imem_ready                      fetch data valid this cycle
//   dmem_req, dmem_ready            MEM-stage access valid / completing
//   perf_clear                      synchronous clear of counters and mem_timeout
//   pc_hold .. exmem_hold           freeze controls
//   ifid_flush, idex_flush          load a NOP into IF/ID, ID/EX
//   memwb_bubble                    load a bubble into MEM/WB
//   state                           RUN=0, MEM_WAIT=1, FLUSH=2
//   mem_timeout                     sticky watchdog flag
//   stall_cycles, redirect_count    saturating performance counters
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int REDIRECT_BUBBLES = 1,
   parameter int TIMEOUT          = 255,
   parameter int CNT_W            = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       ifid_rs1,
   input  logic [4:0]       ifid_rs2,
   input  logic             ifid_uses_rs1,
   input  logic             ifid_uses_rs2,
   input  logic [4:0]       idex_rd,
   input  logic             idex_mem_read,
   input  logic             ex_redirect,
   input  logic             imem_ready,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   input  logic             perf_clear,
   output logic             pc_hold,
   output logic             ifid_hold,
   output logic             idex_hold,
   output logic             exmem_hold,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             memwb_bubble,
   output logic [1:0]       state,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] redirect_count
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   // bubble_cnt holds at most REDIRECT_BUBBLES-1; wait_cnt at most TIMEOUT.
   localparam int BW = (REDIRECT_BUBBLES > 1) ? $clog2(REDIRECT_BUBBLES) : 1;
   localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [BW-1:0] BUBBLE_INIT = BW'(REDIRECT_BUBBLES - 1);
   localparam logic [WW-1:0] TIMEOUT_V   = WW'(TIMEOUT);

   state_t          cur_state, nxt_state;
   state_t          resume_state, nxt_resume;
   state_t          mode;
   logic [BW-1:0]   bubble_cnt, nxt_bubble;
   logic [WW-1:0]   wait_cnt;

   logic            mem_stall;
   logic            load_use;
   logic            redirect_taken;
   logic            timeout_hit;

   // ---------------------------------------------------------------------------
   // Hazard detection
   // ---------------------------------------------------------------------------
   assign mem_stall = dmem_req & ~dmem_ready;

   // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
   assign load_use = idex_mem_read & (idex_rd != 5'd0) &
                     ((ifid_uses_rs1 & (ifid_rs1 == idex_rd)) |
                      (ifid_uses_rs2 & (ifid_rs2 == idex_rd)));

   // While waiting on memory, behave as the state that was interrupted.
   assign mode = (cur_state == MEM_WAIT) ? resume_state : cur_state;

   // A redirect presented during a memory stall is held in EX and retaken later.
   assign redirect_taken = ex_redirect & ~mem_stall;

   // The flag is set on the stall cycle that brings the run length to TIMEOUT.
   assign timeout_hit = (TIMEOUT != 0) && mem_stall && (wait_cnt >= TIMEOUT_V - 1'b1);

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state    <= RUN;
         resume_state <= RUN;
         bubble_cnt   <= '0;
      end else begin
         cur_state    <= nxt_state;
         resume_state <= nxt_resume;
         bubble_cnt   <= nxt_bubble;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every signal assigned here receives a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      nxt_state  = cur_state;
      nxt_resume = resume_state;
      nxt_bubble = bubble_cnt;
      if (mem_stall) begin
         // Entering the wait remembers where to return; bubble_cnt stays frozen.
         if (cur_state != MEM_WAIT) begin
            nxt_state  = MEM_WAIT;
            nxt_resume = cur_state;
         end
      end else if (ex_redirect) begin
         // A redirect (re)starts the wrong-path window, even when already flushing.
         if (REDIRECT_BUBBLES > 1) begin
            nxt_state  = FLUSH;
            nxt_bubble = BUBBLE_INIT;
         end else begin
            nxt_state  = RUN;
            nxt_bubble = '0;
         end
      end else if (mode == FLUSH) begin
         if (bubble_cnt <= BW'(1)) begin
            nxt_state  = RUN;
            nxt_bubble = '0;
         end else begin
            nxt_state  = FLUSH;
            nxt_bubble = bubble_cnt - 1'b1;
         end
      end else begin
         nxt_state = RUN;
      end
   end

   // ---------------------------------------------------------------------------
   // Output logic: fixed priority, first match wins
   // ---------------------------------------------------------------------------
   always_comb begin
      pc_hold      = 1'b0;
      ifid_hold    = 1'b0;
      idex_hold    = 1'b0;
      exmem_hold   = 1'b0;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      memwb_bubble = 1'b0;
      if (mem_stall) begin
         pc_hold      = 1'b1;
         ifid_hold    = 1'b1;
         idex_hold    = 1'b1;
         exmem_hold   = 1'b1;
         memwb_bubble = 1'b1;
      end else if (ex_redirect) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (mode == FLUSH) begin
         // Wrong-path fetches are discarded; a load-use against them is moot.
         ifid_flush = 1'b1;
      end else if (load_use) begin
         pc_hold    = 1'b1;
         ifid_hold  = 1'b1;
         idex_flush = 1'b1;
      end else if (!imem_ready) begin
         pc_hold    = 1'b1;
         ifid_flush = 1'b1;
      end
   end

   assign state = cur_state;

   // ---------------------------------------------------------------------------
   // Watchdog and performance counters
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt       <= '0;
         mem_timeout    <= 1'b0;
         stall_cycles   <= '0;
         redirect_count <= '0;
      end else begin
         // Run length of consecutive stall cycles, saturating at TIMEOUT.
         if (!mem_stall) begin
            wait_cnt <= '0;
         end else if (wait_cnt < TIMEOUT_V) begin
            wait_cnt <= wait_cnt + 1'b1;
         end

         if (perf_clear) begin
            mem_timeout    <= 1'b0;
            stall_cycles   <= '0;
            redirect_count <= '0;
         end else begin
            if (timeout_hit) begin
               mem_timeout <= 1'b1;
            end
            if (pc_hold && (stall_cycles != '1)) begin
               stall_cycles <= stall_cycles + 1'b1;
            end
            if (redirect_taken && (redirect_count != '1)) begin
               redirect_count <= redirect_count + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl. A driver applies one stimulus vector per
// cycle, predicts the full output set from a behavioural model and queues the
// prediction; a monitor on the falling edge pops and compares it against the
// DUT. The model tracks the pipeline in terms of "flush cycles left",
// "waiting on memory" and the current stall run length.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam int RB  = 3;
   localparam int TO  = 8;
   localparam int CW  = 8;
   localparam int MAX = (1 << CW) - 1;

   typedef struct packed {
      logic       rst_n;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       uses_rs1;
      logic       uses_rs2;
      logic [4:0] rd;
      logic       mem_read;
      logic       redirect;
      logic       imem_ready;
      logic       dmem_req;
      logic       dmem_ready;
      logic       perf_clear;
   } stim_t;

   typedef struct packed {
      logic          pc_hold;
      logic          ifid_hold;
      logic          idex_hold;
      logic          exmem_hold;
      logic          ifid_flush;
      logic          idex_flush;
      logic          memwb_bubble;
      logic [1:0]    state;
      logic          mem_timeout;
      logic [CW-1:0] stall_cycles;
      logic [CW-1:0] redirect_count;
   } obs_t;

   logic          clk;
   logic          rst_n;
   logic [4:0]    ifid_rs1, ifid_rs2, idex_rd;
   logic          ifid_uses_rs1, ifid_uses_rs2, idex_mem_read;
   logic          ex_redirect, imem_ready, dmem_req, dmem_ready, perf_clear;
   logic          pc_hold, ifid_hold, idex_hold, exmem_hold;
   logic          ifid_flush, idex_flush, memwb_bubble;
   logic [1:0]    state;
   logic          mem_timeout;
   logic [CW-1:0] stall_cycles, redirect_count;

   hazard_ctrl #(
      .REDIRECT_BUBBLES (RB),
      .TIMEOUT          (TO),
      .CNT_W            (CW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ifid_rs1       (ifid_rs1),
      .ifid_rs2       (ifid_rs2),
      .ifid_uses_rs1  (ifid_uses_rs1),
      .ifid_uses_rs2  (ifid_uses_rs2),
      .idex_rd        (idex_rd),
      .idex_mem_read  (idex_mem_read),
      .ex_redirect    (ex_redirect),
      .imem_ready     (imem_ready),
      .dmem_req       (dmem_req),
      .dmem_ready     (dmem_ready),
      .perf_clear     (perf_clear),
      .pc_hold        (pc_hold),
      .ifid_hold      (ifid_hold),
      .idex_hold      (idex_hold),
      .exmem_hold     (exmem_hold),
      .ifid_flush     (ifid_flush),
      .idex_flush     (idex_flush),
      .memwb_bubble   (memwb_bubble),
      .state          (state),
      .mem_timeout    (mem_timeout),
      .stall_cycles   (stall_cycles),
      .redirect_count (redirect_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------------------------------------------------------------------
   // Scoreboard bookkeeping
   // ---------------------------------------------------------------------------
   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cycle_no = 0;

   task automatic check(input string name, input obs_t act, input obs_t exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got hold=%b%b%b%b flush=%b%b bub=%b st=%0d to=%b stall=%0d redir=%0d, expected hold=%b%b%b%b flush=%b%b bub=%b st=%0d to=%b stall=%0d redir=%0d",
                  name,
                  act.pc_hold, act.ifid_hold, act.idex_hold, act.exmem_hold,
                  act.ifid_flush, act.idex_flush, act.memwb_bubble, act.state,
                  act.mem_timeout, act.stall_cycles, act.redirect_count,
                  exp.pc_hold, exp.ifid_hold, exp.idex_hold, exp.exmem_hold,
                  exp.ifid_flush, exp.idex_flush, exp.memwb_bubble, exp.state,
                  exp.mem_timeout, exp.stall_cycles, exp.redirect_count);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural reference model
   // ---------------------------------------------------------------------------
   int m_left;       // wrong-path fetch cycles still to discard
   bit m_waiting;    // a data-memory wait is in progress
   int m_wait_run;   // length of the current stall run
   bit m_to;
   int m_stall;
   int m_redir;

   function automatic void model_reset();
      m_left     = 0;
      m_waiting  = 1'b0;
      m_wait_run = 0;
      m_to       = 1'b0;
      m_stall    = 0;
      m_redir    = 0;
   endfunction

   function automatic obs_t model_out(input stim_t s);
      obs_t o;
      bit   ms, lu;
      ms = s.dmem_req && !s.dmem_ready;
      lu = s.mem_read && (s.rd != 0) &&
           ((s.uses_rs1 && (s.rs1 == s.rd)) || (s.uses_rs2 && (s.rs2 == s.rd)));
      o = '0;
      if (ms) begin
         o.pc_hold = 1; o.ifid_hold = 1; o.idex_hold = 1; o.exmem_hold = 1;
         o.memwb_bubble = 1;
      end else if (s.redirect) begin
         o.ifid_flush = 1; o.idex_flush = 1;
      end else if (m_left > 0) begin
         o.ifid_flush = 1;
      end else if (lu) begin
         o.pc_hold = 1; o.ifid_hold = 1; o.idex_flush = 1;
      end else if (!s.imem_ready) begin
         o.pc_hold = 1; o.ifid_flush = 1;
      end
      o.state          = m_waiting ? 2'd1 : ((m_left > 0) ? 2'd2 : 2'd0);
      o.mem_timeout    = m_to;
      o.stall_cycles   = CW'(m_stall);
      o.redirect_count = CW'(m_redir);
      return o;
   endfunction

   function automatic void model_step(input stim_t s, input obs_t o);
      bit ms;
      ms = s.dmem_req && !s.dmem_ready;
      if (ms) begin
         m_waiting = 1'b1;
         m_wait_run++;
         if (m_wait_run >= TO) m_to = 1'b1;
      end else begin
         m_waiting  = 1'b0;
         m_wait_run = 0;
         if (s.redirect) m_left = RB - 1;
         else if (m_left > 0) m_left--;
      end
      if (s.perf_clear) begin
         m_to    = 1'b0;
         m_stall = 0;
         m_redir = 0;
      end else begin
         if (o.pc_hold && m_stall < MAX) m_stall++;
         if (!ms && s.redirect && m_redir < MAX) m_redir++;
      end
   endfunction

   // ---------------------------------------------------------------------------
   // Driver
   // ---------------------------------------------------------------------------
   function automatic stim_t idle();
      stim_t s;
      s = '0;
      s.rst_n      = 1'b1;
      s.imem_ready = 1'b1;
      s.dmem_ready = 1'b1;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      obs_t o;
      @(posedge clk);
      #1;
      rst_n         = s.rst_n;
      ifid_rs1      = s.rs1;
      ifid_rs2      = s.rs2;
      ifid_uses_rs1 = s.uses_rs1;
      ifid_uses_rs2 = s.uses_rs2;
      idex_rd       = s.rd;
      idex_mem_read = s.mem_read;
      ex_redirect   = s.redirect;
      imem_ready    = s.imem_ready;
      dmem_req      = s.dmem_req;
      dmem_ready    = s.dmem_ready;
      perf_clear    = s.perf_clear;
      if (!s.rst_n) model_reset();
      o = model_out(s);
      exp_q.push_back(o);
      if (s.rst_n) model_step(s, o);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) apply(idle());
   endtask

   task automatic stall_cycles_task(input int n);
      stim_t s;
      s = idle();
      s.dmem_req   = 1'b1;
      s.dmem_ready = 1'b0;
      for (int i = 0; i < n; i++) apply(s);
   endtask

   // ---------------------------------------------------------------------------
   // Monitor: compares once per cycle, away from the active edge
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      obs_t act;
      if (exp_q.size() > 0) begin
         act.pc_hold        = pc_hold;
         act.ifid_hold      = ifid_hold;
         act.idex_hold      = idex_hold;
         act.exmem_hold     = exmem_hold;
         act.ifid_flush     = ifid_flush;
         act.idex_flush     = idex_flush;
         act.memwb_bubble   = memwb_bubble;
         act.state          = state;
         act.mem_timeout    = mem_timeout;
         act.stall_cycles   = stall_cycles;
         act.redirect_count = redirect_count;
         check($sformatf("cycle_%0d", cycle_no), act, exp_q.pop_front());
         cycle_no++;
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      stim_t s;
      int    burst;

      model_reset();
      rst_n = 1'b0;
      ifid_rs1 = '0; ifid_rs2 = '0; idex_rd = '0;
      ifid_uses_rs1 = 1'b0; ifid_uses_rs2 = 1'b0; idex_mem_read = 1'b0;
      ex_redirect = 1'b0; imem_ready = 1'b1; dmem_req = 1'b0;
      dmem_ready = 1'b1; perf_clear = 1'b0;

      // Reset state, then idle.
      s = idle(); s.rst_n = 1'b0;
      apply(s); apply(s);
      idle_cycles(2);

      // Load-use on rs2: one bubble, then clean.
      s = idle(); s.mem_read = 1; s.rd = 5'd5; s.rs2 = 5'd5; s.uses_rs2 = 1;
      apply(s);
      idle_cycles(2);

      // Redirect pulse: three flush cycles.
      s = idle(); s.redirect = 1;
      apply(s);
      idle_cycles(3);

      // Memory stall in the middle of a flush window.
      apply(s);
      stall_cycles_task(4);
      idle_cycles(3);

      // Redirect presented while stalled, then retaken.
      s = idle(); s.redirect = 1; s.dmem_req = 1; s.dmem_ready = 0;
      apply(s); apply(s);
      s.dmem_req = 0;
      apply(s);
      idle_cycles(3);

      // Watchdog: 10 stall cycles, then clear.
      stall_cycles_task(10);
      idle_cycles(2);
      s = idle(); s.perf_clear = 1;
      apply(s);
      idle_cycles(2);

      // x0 load never stalls; fetch not ready on the same cycle.
      s = idle(); s.mem_read = 1; s.rd = 5'd0; s.rs1 = 5'd0; s.uses_rs1 = 1;
      apply(s);
      s.imem_ready = 0;
      apply(s);
      idle_cycles(1);

      // Load-use during a flush window is ignored.
      s = idle(); s.redirect = 1;
      apply(s);
      s = idle(); s.mem_read = 1; s.rd = 5'd7; s.rs1 = 5'd7; s.uses_rs1 = 1;
      apply(s);
      idle_cycles(2);

      // Reset asserted in the second MEM_WAIT cycle.
      s = idle(); s.redirect = 1;
      apply(s);
      stall_cycles_task(2);
      s = idle(); s.dmem_req = 1; s.dmem_ready = 0; s.rst_n = 0;
      apply(s);
      s = idle(); s.rst_n = 0;
      apply(s);
      idle_cycles(3);

      // Random traffic; the first phase never clears so counters saturate.
      burst = 0;
      for (int ph = 0; ph < 2; ph++) begin
         for (int i = 0; i < ((ph == 0) ? 2500 : 1000); i++) begin
            s = idle();
            s.rs1        = 5'($urandom_range(0, 3));
            s.rs2        = 5'($urandom_range(0, 3));
            s.rd         = 5'($urandom_range(0, 3));
            s.uses_rs1   = ($urandom_range(0, 1) == 1);
            s.uses_rs2   = ($urandom_range(0, 1) == 1);
            s.mem_read   = ($urandom_range(0, 9) < 4);
            s.redirect   = ($urandom_range(0, 9) < 2);
            s.imem_ready = ($urandom_range(0, 9) < 8);
            s.dmem_req   = ($urandom_range(0, 9) < 3);
            s.dmem_ready = ($urandom_range(0, 1) == 1);
            s.perf_clear = (ph == 1) && ($urandom_range(0, 49) == 0);
            if (burst == 0 && $urandom_range(0, 59) == 0) burst = $urandom_range(1, 12);
            if (burst > 0) begin
               s.dmem_req   = 1;
               s.dmem_ready = 0;
               burst--;
            end
            apply(s);
         end
      end
      idle_cycles(2);

      // Let the monitor drain, bounded.
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: got %0d pending predictions, expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
